// File: rtl/usb_host_ep_scheduler.sv
// usb_host_ep_scheduler: SOF per frame, round-robin endpoint channel arbitration, toggle/retry tracking.
// Latency: ch_req -> tok_valid in 2 cycles (idle, no SOF, guard ok); hs_valid/err_valid -> done_valid in 1 cycle.
// Backpressure: token fields held until tok_ready; SOF_WAIT holds until sof_done; ch_req on a busy channel is dropped.
//
// Ports:
//   SIE_clk, reset_SIE                       clock, async active-high reset
//   ch_req/ch_dir/ch_dev_addr/ch_ep_addr/ch_len   per-channel descriptor load (packed, channel i at slice i)
//   toggle_clr                               per-channel force toggle to DATA0
//   ch_busy                                  channel pending or in flight
//   tok_valid/tok_ready/tok_pid/tok_addr/tok_ep/tok_toggle/tok_len   token request to SIE
//   sof_frame, sof_done                      frame number, SIE SOF-sent pulse
//   hs_valid/hs_code, err_valid              transaction outcome from SIE
//   done_valid/done_ch/done_status           per-transfer completion pulse
module usb_host_ep_scheduler #(
   parameter int  N_CH        = 4,
   parameter int  FRAME_TICKS = 12000,
   parameter int  GUARD_TICKS = 600,
   parameter int  RETRY_MAX   = 3,
   parameter int  LEN_W       = 6,
   parameter int  FN_W        = 11,
   localparam int CH_W        = $clog2(N_CH)
) (
   input  logic                  SIE_clk,
   input  logic                  reset_SIE,
   input  logic [N_CH-1:0]       ch_req,
   input  logic [N_CH-1:0]       ch_dir,
   input  logic [7*N_CH-1:0]     ch_dev_addr,
   input  logic [4*N_CH-1:0]     ch_ep_addr,
   input  logic [LEN_W*N_CH-1:0] ch_len,
   input  logic [N_CH-1:0]       toggle_clr,
   output logic [N_CH-1:0]       ch_busy,
   output logic                  tok_valid,
   input  logic                  tok_ready,
   output logic [7:0]            tok_pid,
   output logic [6:0]            tok_addr,
   output logic [3:0]            tok_ep,
   output logic                  tok_toggle,
   output logic [LEN_W-1:0]      tok_len,
   output logic [FN_W-1:0]       sof_frame,
   input  logic                  sof_done,
   input  logic                  hs_valid,
   input  logic [1:0]            hs_code,
   input  logic                  err_valid,
   output logic                  done_valid,
   output logic [CH_W-1:0]       done_ch,
   output logic [1:0]            done_status
);
   localparam int TICK_W = $clog2(FRAME_TICKS);
   localparam int RTY_W  = $clog2(RETRY_MAX + 1);
   localparam logic [7:0] PID_OUT = 8'hE1;
   localparam logic [7:0] PID_IN  = 8'h69;
   localparam logic [7:0] PID_SOF = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE, S_SOF, S_SOF_WAIT, S_ARB, S_TOKEN, S_WAIT_RESP
   } state_t;

   state_t state, state_nxt;

   logic [TICK_W-1:0] tick_cnt;
   logic              sof_pend;
   logic              guard_ok;

   logic [N_CH-1:0]   pending;
   logic [N_CH-1:0]   toggle;
   logic [RTY_W-1:0]  retry  [N_CH];
   logic              dir_q  [N_CH];
   logic [6:0]        dev_q  [N_CH];
   logic [3:0]        ep_q   [N_CH];
   logic [LEN_W-1:0]  len_q  [N_CH];

   logic [CH_W-1:0]   rr;
   logic [CH_W-1:0]   gnt_ch;
   logic [CH_W-1:0]   arb_ch;
   logic              arb_found;

   logic [7:0]        lat_pid;
   logic [6:0]        lat_addr;
   logic [3:0]        lat_ep;
   logic              lat_toggle;
   logic [LEN_W-1:0]  lat_len;

   logic              resolve;
   logic              is_err;
   logic              retry_last;

   // tick_cnt is the number of ticks remaining in the current frame
   assign guard_ok   = (tick_cnt >= TICK_W'(GUARD_TICKS));
   assign resolve    = err_valid | hs_valid;
   // a bus error overrides any handshake seen in the same cycle
   assign is_err     = err_valid | (hs_code == 2'b11);
   assign retry_last = (int'(retry[gnt_ch]) + 1) >= RETRY_MAX;
   assign ch_busy    = pending;

   // ---------------- frame timer / SOF bookkeeping ----------------
   always_ff @(posedge SIE_clk or posedge reset_SIE) begin
      if (reset_SIE) begin
         tick_cnt  <= TICK_W'(FRAME_TICKS - 1);
         sof_pend  <= 1'b0;
         sof_frame <= '0;
      end else begin
         if (tick_cnt == '0) tick_cnt <= TICK_W'(FRAME_TICKS - 1);
         else                tick_cnt <= tick_cnt - 1'b1;

         if (state == S_SOF && tok_ready) sof_frame <= sof_frame + 1'b1;

         // a new frame boundary takes priority over clearing the previous request
         if (tick_cnt == '0)                          sof_pend <= 1'b1;
         else if (state == S_SOF_WAIT && sof_done)    sof_pend <= 1'b0;
      end
   end

   // ---------------- round-robin search from rr ----------------
   always_comb begin
      logic [CH_W:0] idx;
      arb_found = 1'b0;
      arb_ch    = '0;
      idx       = '0;
      for (int i = 0; i < N_CH; i++) begin
         idx = {1'b0, rr} + (CH_W+1)'(i);
         if (idx >= (CH_W+1)'(N_CH)) idx = idx - (CH_W+1)'(N_CH);
         if (!arb_found && pending[idx[CH_W-1:0]]) begin
            arb_found = 1'b1;
            arb_ch    = idx[CH_W-1:0];
         end
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge SIE_clk or posedge reset_SIE) begin
      if (reset_SIE) state <= S_IDLE;
      else           state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   // IDLE also looks at ch_req directly so a fresh request reaches ARB one
   // cycle earlier; by then the request is registered into pending.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (sof_pend)                                state_nxt = S_SOF;
            else if ((|(pending | ch_req)) && guard_ok)  state_nxt = S_ARB;
         end
         S_SOF:       if (tok_ready) state_nxt = S_SOF_WAIT;
         S_SOF_WAIT:  if (sof_done)  state_nxt = S_IDLE;
         S_ARB:       state_nxt = arb_found ? S_TOKEN : S_IDLE;
         S_TOKEN:     if (tok_ready) state_nxt = S_WAIT_RESP;
         S_WAIT_RESP: if (resolve)   state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      tok_valid  = 1'b0;
      tok_pid    = '0;
      tok_addr   = '0;
      tok_ep     = '0;
      tok_toggle = 1'b0;
      tok_len    = '0;
      case (state)
         S_SOF: begin
            tok_valid = 1'b1;
            tok_pid   = PID_SOF;
         end
         S_TOKEN: begin
            tok_valid  = 1'b1;
            tok_pid    = lat_pid;
            tok_addr   = lat_addr;
            tok_ep     = lat_ep;
            tok_toggle = lat_toggle;
            tok_len    = lat_len;
         end
         default: ;
      endcase
   end

   // ---------------- channel state, grant latch, completion ----------------
   always_ff @(posedge SIE_clk or posedge reset_SIE) begin
      if (reset_SIE) begin
         pending     <= '0;
         toggle      <= '0;
         rr          <= '0;
         gnt_ch      <= '0;
         lat_pid     <= '0;
         lat_addr    <= '0;
         lat_ep      <= '0;
         lat_toggle  <= 1'b0;
         lat_len     <= '0;
         done_valid  <= 1'b0;
         done_ch     <= '0;
         done_status <= '0;
         for (int i = 0; i < N_CH; i++) begin
            retry[i] <= '0;
            dir_q[i] <= 1'b0;
            dev_q[i] <= '0;
            ep_q[i]  <= '0;
            len_q[i] <= '0;
         end
      end else begin
         done_valid <= 1'b0;

         // descriptor load; a channel already pending keeps its descriptor
         for (int i = 0; i < N_CH; i++) begin
            if (ch_req[i] && !pending[i]) begin
               pending[i] <= 1'b1;
               dir_q[i]   <= ch_dir[i];
               dev_q[i]   <= ch_dev_addr[i*7 +: 7];
               ep_q[i]    <= ch_ep_addr[i*4 +: 4];
               len_q[i]   <= ch_len[i*LEN_W +: LEN_W];
            end
         end

         if (state == S_ARB && arb_found) begin
            gnt_ch     <= arb_ch;
            lat_pid    <= dir_q[arb_ch] ? PID_IN : PID_OUT;
            lat_addr   <= dev_q[arb_ch];
            lat_ep     <= ep_q[arb_ch];
            lat_toggle <= toggle[arb_ch];
            lat_len    <= len_q[arb_ch];
         end

         if (state == S_WAIT_RESP && resolve) begin
            rr <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
            if (is_err) begin
               if (retry_last) begin
                  pending[gnt_ch] <= 1'b0;
                  retry[gnt_ch]   <= '0;
                  done_valid      <= 1'b1;
                  done_ch         <= gnt_ch;
                  done_status     <= 2'b10;
               end else begin
                  retry[gnt_ch] <= retry[gnt_ch] + 1'b1;
               end
            end else if (hs_code == 2'b00) begin
               toggle[gnt_ch]  <= ~toggle[gnt_ch];
               pending[gnt_ch] <= 1'b0;
               retry[gnt_ch]   <= '0;
               done_valid      <= 1'b1;
               done_ch         <= gnt_ch;
               done_status     <= 2'b00;
            end else if (hs_code == 2'b10) begin
               pending[gnt_ch] <= 1'b0;
               retry[gnt_ch]   <= '0;
               done_valid      <= 1'b1;
               done_ch         <= gnt_ch;
               done_status     <= 2'b01;
            end
            // NAK: channel stays pending, nothing else changes
         end

         // placed last so a clear overrides an ACK flip in the same cycle
         for (int i = 0; i < N_CH; i++) begin
            if (toggle_clr[i]) toggle[i] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_usb_host_ep_scheduler.sv
// tb_usb_host_ep_scheduler: directed scenarios followed by randomized traffic against a reference model.
// Latency: n/a (testbench).
// Backpressure: drives tok_ready with random stalls in the random phase.
module tb_usb_host_ep_scheduler;
   localparam int N_CH        = 4;
   localparam int FRAME_TICKS = 300;
   localparam int GUARD_TICKS = 40;
   localparam int RETRY_MAX   = 3;
   localparam int LEN_W       = 6;
   localparam int FN_W        = 3;
   localparam int CH_W        = 2;

   logic                  SIE_clk = 1'b0;
   logic                  reset_SIE = 1'b1;
   logic [N_CH-1:0]       ch_req = '0;
   logic [N_CH-1:0]       ch_dir;
   logic [7*N_CH-1:0]     ch_dev_addr;
   logic [4*N_CH-1:0]     ch_ep_addr;
   logic [LEN_W*N_CH-1:0] ch_len;
   logic [N_CH-1:0]       toggle_clr = '0;
   logic [N_CH-1:0]       ch_busy;
   logic                  tok_valid;
   logic                  tok_ready = 1'b0;
   logic [7:0]            tok_pid;
   logic [6:0]            tok_addr;
   logic [3:0]            tok_ep;
   logic                  tok_toggle;
   logic [LEN_W-1:0]      tok_len;
   logic [FN_W-1:0]       sof_frame;
   logic                  sof_done = 1'b0;
   logic                  hs_valid = 1'b0;
   logic [1:0]            hs_code = 2'b00;
   logic                  err_valid = 1'b0;
   logic                  done_valid;
   logic [CH_W-1:0]       done_ch;
   logic [1:0]            done_status;

   usb_host_ep_scheduler #(
      .N_CH(N_CH), .FRAME_TICKS(FRAME_TICKS), .GUARD_TICKS(GUARD_TICKS),
      .RETRY_MAX(RETRY_MAX), .LEN_W(LEN_W), .FN_W(FN_W)
   ) dut (
      .SIE_clk(SIE_clk), .reset_SIE(reset_SIE),
      .ch_req(ch_req), .ch_dir(ch_dir), .ch_dev_addr(ch_dev_addr),
      .ch_ep_addr(ch_ep_addr), .ch_len(ch_len), .toggle_clr(toggle_clr),
      .ch_busy(ch_busy), .tok_valid(tok_valid), .tok_ready(tok_ready),
      .tok_pid(tok_pid), .tok_addr(tok_addr), .tok_ep(tok_ep),
      .tok_toggle(tok_toggle), .tok_len(tok_len), .sof_frame(sof_frame),
      .sof_done(sof_done), .hs_valid(hs_valid), .hs_code(hs_code),
      .err_valid(err_valid), .done_valid(done_valid), .done_ch(done_ch),
      .done_status(done_status)
   );

   always #5 SIE_clk = ~SIE_clk;

   // descriptor values presented on the request bus
   logic             d_dir [N_CH];
   logic [6:0]       d_dev [N_CH];
   logic [3:0]       d_ep  [N_CH];
   logic [LEN_W-1:0] d_len [N_CH];

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         ch_dir[i]                   = d_dir[i];
         ch_dev_addr[i*7 +: 7]       = d_dev[i];
         ch_ep_addr[i*4 +: 4]        = d_ep[i];
         ch_len[i*LEN_W +: LEN_W]    = d_len[i];
      end
   end

   // clock edges since reset release; the frame timer position follows from it
   int cyc;
   always @(posedge SIE_clk or posedge reset_SIE) begin
      if (reset_SIE) cyc <= 0;
      else           cyc <= cyc + 1;
   end

   // ---------------- reference model ----------------
   bit   m_pend [N_CH];
   bit   m_tog  [N_CH];
   int   m_retry[N_CH];
   bit   m_dir  [N_CH];
   int   m_dev  [N_CH];
   int   m_ep   [N_CH];
   int   m_len  [N_CH];
   int   m_rr;
   int   m_frame;

   int   n_tests;
   int   n_fail;
   bit   saw_sof;
   int   tok_wait;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_pend[i] = 0; m_tog[i] = 0; m_retry[i] = 0;
      end
      m_rr    = 0;
      m_frame = 0;
   endfunction

   function automatic int rem_at(input int k);
      int r;
      r = (FRAME_TICKS - 1 - k) % FRAME_TICKS;
      if (r < 0) r += FRAME_TICKS;
      return r;
   endfunction

   function automatic int exp_grant();
      for (int k = 0; k < N_CH; k++) begin
         if (m_pend[(m_rr + k) % N_CH]) return (m_rr + k) % N_CH;
      end
      return -1;
   endfunction

   function automatic logic [N_CH-1:0] pend_mask();
      logic [N_CH-1:0] m;
      for (int i = 0; i < N_CH; i++) m[i] = m_pend[i];
      return m;
   endfunction

   function automatic bit any_pend();
      return |pend_mask();
   endfunction

   // called at a negedge; drives ch_req for exactly one cycle
   task automatic pulse_req(input logic [N_CH-1:0] mask);
      for (int i = 0; i < N_CH; i++) begin
         if (mask[i] && !m_pend[i]) begin
            m_pend[i] = 1;
            m_dir[i]  = d_dir[i];
            m_dev[i]  = int'(d_dev[i]);
            m_ep[i]   = int'(d_ep[i]);
            m_len[i]  = int'(d_len[i]);
         end
      end
      ch_req = mask;
      @(negedge SIE_clk);
      ch_req = '0;
   endtask

   // Serves any SOFs, then one data token answered with resp:
   // 0 ACK, 1 NAK, 2 STALL, 3 hs_code 11, 4 err_valid, 5 err_valid+ACK, -1 reset while awaiting response
   task automatic serve(input int resp, input logic [N_CH-1:0] clr, input bit rnd);
      int waited;
      int g;
      int d;
      bit exp_done;
      logic [1:0] exp_st;
      logic [25:0] first;
      waited  = 0;
      saw_sof = 0;
      tok_wait = 0;
      forever begin
         @(negedge SIE_clk);
         waited++;
         if (waited > 3 * FRAME_TICKS) begin
            chk("token_timeout", 32'd0, 32'd1);
            return;
         end
         if (tok_valid && tok_pid == 8'hA5) begin
            saw_sof = 1;
            chk("sof_fields", {tok_addr, tok_ep, tok_toggle, tok_len}, 32'd0);
            chk("sof_frame_pre", 32'(sof_frame), 32'(m_frame));
            tok_ready = 1'b1;
            @(negedge SIE_clk);
            tok_ready = 1'b0;
            m_frame = (m_frame + 1) % (1 << FN_W);
            chk("sof_frame_post", 32'(sof_frame), 32'(m_frame));
            sof_done = 1'b1;
            @(negedge SIE_clk);
            sof_done = 1'b0;
         end else if (tok_valid) begin
            tok_wait = waited;
            g = exp_grant();
            if (g < 0) begin
               chk("unexpected_token", 32'd1, 32'd0);
               return;
            end
            chk("tok_pid",    32'(tok_pid), m_dir[g] ? 32'h69 : 32'hE1);
            chk("tok_addr",   32'(tok_addr), 32'(m_dev[g]));
            chk("tok_ep",     32'(tok_ep), 32'(m_ep[g]));
            chk("tok_len",    32'(tok_len), 32'(m_len[g]));
            chk("tok_toggle", 32'(tok_toggle), 32'(m_tog[g]));
            chk("tok_guard",  32'(rem_at(cyc - 2) >= GUARD_TICKS), 32'd1);
            first = {tok_pid, tok_addr, tok_ep, tok_toggle, tok_len};
            d = rnd ? $urandom_range(0, 2) : 0;
            repeat (d) begin
               @(negedge SIE_clk);
               chk("tok_hold", {5'd0, tok_valid, first ^ {tok_pid, tok_addr, tok_ep, tok_toggle, tok_len}},
                   32'h0400_0000);
            end
            tok_ready = 1'b1;
            @(negedge SIE_clk);
            tok_ready = 1'b0;
            chk("tok_drop", 32'(tok_valid), 32'd0);
            if (resp < 0) begin
               reset_SIE = 1'b1;
               @(negedge SIE_clk);
               chk("rst_tok", {tok_valid, tok_pid, tok_addr, tok_ep, tok_toggle, tok_len}, 32'd0);
               chk("rst_busy", 32'(ch_busy), 32'd0);
               chk("rst_done", {done_valid, done_ch, done_status}, 32'd0);
               chk("rst_frame", 32'(sof_frame), 32'd0);
               repeat (2) begin
                  @(negedge SIE_clk);
                  chk("rst_no_done", 32'(done_valid), 32'd0);
               end
               model_reset();
               reset_SIE = 1'b0;
               return;
            end
            d = rnd ? $urandom_range(0, 2) : 0;
            repeat (d) begin
               @(negedge SIE_clk);
               chk("no_early_done", 32'(done_valid), 32'd0);
            end
            case (resp)
               0: begin hs_valid = 1'b1; hs_code = 2'b00; end
               1: begin hs_valid = 1'b1; hs_code = 2'b01; end
               2: begin hs_valid = 1'b1; hs_code = 2'b10; end
               3: begin hs_valid = 1'b1; hs_code = 2'b11; end
               4: begin err_valid = 1'b1; end
               default: begin err_valid = 1'b1; hs_valid = 1'b1; hs_code = 2'b00; end
            endcase
            toggle_clr = clr;
            @(negedge SIE_clk);
            hs_valid = 1'b0; err_valid = 1'b0; hs_code = 2'b00; toggle_clr = '0;

            exp_done = 0;
            exp_st   = 2'b00;
            if (resp >= 3) begin
               m_retry[g]++;
               if (m_retry[g] >= RETRY_MAX) begin
                  m_pend[g] = 0; m_retry[g] = 0; exp_done = 1; exp_st = 2'b10;
               end
            end else if (resp == 0) begin
               m_tog[g] = !m_tog[g]; m_pend[g] = 0; m_retry[g] = 0; exp_done = 1; exp_st = 2'b00;
            end else if (resp == 2) begin
               m_pend[g] = 0; m_retry[g] = 0; exp_done = 1; exp_st = 2'b01;
            end
            for (int i = 0; i < N_CH; i++) if (clr[i]) m_tog[i] = 0;
            m_rr = (g + 1) % N_CH;

            chk("done_valid", 32'(done_valid), 32'(exp_done));
            if (exp_done) begin
               chk("done_ch",     32'(done_ch), 32'(g));
               chk("done_status", 32'(done_status), 32'(exp_st));
            end
            chk("ch_busy", 32'(ch_busy), 32'(pend_mask()));
            return;
         end
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      int r;
      int resp;
      logic [N_CH-1:0] mask;
      logic [N_CH-1:0] clr;

      n_tests = 0;
      n_fail  = 0;
      model_reset();
      for (int i = 0; i < N_CH; i++) begin
         d_dir[i] = 1'b0; d_dev[i] = 7'(i + 1); d_ep[i] = 4'(i); d_len[i] = LEN_W'(i + 4);
      end

      // reset state
      repeat (3) @(negedge SIE_clk);
      chk("reset_tok", {tok_valid, tok_pid, tok_addr, tok_ep, tok_toggle, tok_len}, 32'd0);
      chk("reset_busy", 32'(ch_busy), 32'd0);
      chk("reset_done", {done_valid, done_ch, done_status}, 32'd0);
      chk("reset_frame", 32'(sof_frame), 32'd0);
      reset_SIE = 1'b0;

      // first SOF after a full frame
      w = 0;
      while (!tok_valid && w < FRAME_TICKS + 10) begin
         @(negedge SIE_clk);
         w++;
      end
      chk("sof_first_pid", 32'(tok_pid), 32'hA5);
      chk("sof_first_time", 32'(cyc >= FRAME_TICKS - 1 && cyc <= FRAME_TICKS + 1), 32'd1);
      chk("sof_first_frame0", 32'(sof_frame), 32'd0);
      tok_ready = 1'b1;
      @(negedge SIE_clk);
      tok_ready = 1'b0;
      chk("sof_first_frame1", 32'(sof_frame), 32'd1);
      m_frame = 1;
      sof_done = 1'b1;
      @(negedge SIE_clk);
      sof_done = 1'b0;

      // channels 0 and 2, OUT, always ACK: 0,2,0,2 with toggles 0,0,1,1
      d_dev[0] = 7'h11; d_ep[0] = 4'h1; d_len[0] = 6'd8;
      d_dev[2] = 7'h22; d_ep[2] = 4'h2; d_len[2] = 6'd16;
      pulse_req(4'b0101);
      chk("req_lat_t1", 32'(tok_valid), 32'd0);
      serve(0, '0, 0);
      chk("req_lat_t2", 32'(tok_wait), 32'd1);
      pulse_req(4'b0001);
      serve(0, '0, 0);
      pulse_req(4'b0100);
      serve(0, '0, 0);
      serve(0, '0, 0);

      // channel 1 IN, three errors -> ERR; toggle still DATA0 afterwards
      d_dir[1] = 1'b1; d_dev[1] = 7'h33; d_ep[1] = 4'h5; d_len[1] = 6'd63;
      pulse_req(4'b0010);
      repeat (3) serve(4, '0, 0);
      pulse_req(4'b0010);
      serve(0, '0, 0);

      // channel 3 NAK x5 then ACK
      d_dir[3] = 1'b1; d_dev[3] = 7'h7F; d_ep[3] = 4'hF; d_len[3] = 6'd1;
      pulse_req(4'b1000);
      repeat (5) serve(1, '0, 0);
      serve(0, '0, 0);

      // request arriving inside the guard window waits for the next SOF
      w = 0;
      while (rem_at(cyc) != GUARD_TICKS - 1 && w < 2 * FRAME_TICKS) begin
         @(negedge SIE_clk);
         w++;
      end
      pulse_req(4'b0001);
      serve(0, '0, 0);
      chk("guard_sof_first", 32'(saw_sof), 32'd1);

      // toggle_clr together with ACK on channel 0 (toggle currently 1)
      pulse_req(4'b0001);
      serve(0, 4'b0001, 0);
      pulse_req(4'b0001);
      serve(0, '0, 0);

      // randomized traffic
      for (int it = 0; it < 250; it++) begin
         for (int i = 0; i < N_CH; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               d_dir[i] = 1'($urandom_range(0, 1));
               d_dev[i] = 7'($urandom_range(0, 127));
               d_ep[i]  = 4'($urandom_range(0, 15));
               d_len[i] = LEN_W'($urandom_range(0, 63));
            end
         end
         mask = N_CH'($urandom_range(0, 15));
         pulse_req(mask);
         if (any_pend()) begin
            r = $urandom_range(0, 9);
            resp = (r <= 3) ? 0 : (r <= 5) ? 1 : (r == 6) ? 2 : (r == 7) ? 3 : (r == 8) ? 4 : 5;
            clr = ($urandom_range(0, 3) == 0) ? N_CH'($urandom_range(1, 15)) : '0;
            serve(resp, clr, 1);
         end else begin
            repeat ($urandom_range(0, 3)) @(negedge SIE_clk);
         end
      end

      // reset while waiting for a response: everything clears, no done pulse
      while (any_pend()) serve(0, '0, 0);
      pulse_req(4'b0010);
      serve(-1, '0, 0);
      pulse_req(4'b0100);
      serve(0, '0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
